// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the 16-bit pipeline stages.
//   - Opcode field values (instruction bits [15:12]) used by decode.
//   - NOP_INSTR: the all-zero word the fetch stage inserts as a bubble.
//   - fetch_state_t: fetch-side memory handshake state.
package pipe_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hC;
  localparam logic [3:0] OP_BZ   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // IDLE: nothing outstanding; WAIT: one fetch outstanding;
  // DROP: one fetch outstanding whose response is discarded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/grant/response bus.
//   imem_req    : fetch request valid            (master -> slave)
//   imem_addr   : word address of the fetch      (master -> slave)
//   imem_gnt    : request accepted this cycle    (slave -> master)
//   imem_rvalid : response data valid            (slave -> master)
//   imem_rdata  : fetched instruction word       (slave -> master)
interface fetch_stage_if #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 16
) ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding buffer for a fetch response that
// arrives while the IF/ID register is stalled.
//   clock, rst_n      : clock, asynchronous active-low reset
//   load_i            : capture {instr_i, pc1_i}, buffer becomes full
//   unload_i          : buffer contents consumed, buffer becomes empty
//   clear_i           : discard contents (highest priority)
//   instr_i, pc1_i    : payload to capture
//   full_o            : buffer holds a payload
//   instr_o, pc1_o    : buffered payload
module fetch_skid_buf #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc1_i,
  output logic               full_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc1_o
);

  logic               full_q, full_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc1_q, pc1_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d  = 1'b1;
      instr_d = instr_i;
      pc1_d   = pc1_i;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc1_q   <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc1_o   = pc1_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch plus IF/ID pipeline register.
//   clock, rst_n   : clock, asynchronous active-low reset
//   imem           : instruction-memory bus (master side), at most one
//                    fetch outstanding; imem_addr always equals the PC
//   stall          : hold IF/ID and PC (requests continue until skid full)
//   branch_en/jump : redirect PC to target; squashes any in-flight fetch
//   target         : redirect address
//   if_id_instr    : instruction to decode (0x0000 when bubble)
//   if_id_pc1      : address of if_id_instr plus one
//   if_id_valid    : if_id_instr is a real fetched instruction
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               rst_n,
  fetch_stage_if.master      imem,
  input  logic               stall,
  input  logic               branch_en,
  input  logic               jump,
  input  logic [PC_W-1:0]    target,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc1,
  output logic               if_id_valid
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc1_q, pc1_d;
  logic               valid_q, valid_d;

  logic               redirect;
  logic               req;
  logic               accept;
  logic               resp_ok;
  logic               skid_full;
  logic               skid_load;
  logic               skid_unload;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc1;

  assign redirect = branch_en | jump;

  // Redirect gates the request combinationally so no accept can race a
  // PC reload. Reset also gates it so req reads low while rst_n is low.
  assign req     = rst_n & (state_q == IDLE) & ~skid_full & ~redirect;
  assign accept  = req & imem.imem_gnt;
  assign resp_ok = (state_q == WAIT) & imem.imem_rvalid;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = WAIT;
      WAIT: begin
        if (imem.imem_rvalid) state_d = IDLE;
        else if (redirect)    state_d = DROP;
      end
      DROP: if (imem.imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      pc_d = target;
    end else if (accept) begin
      pc_d       = pc_q + 1'b1;
      fetch_pc_d = pc_q;
    end
  end

  // Skid captures a good response only when stalled and not redirected;
  // it drains into IF/ID as soon as the stall drops.
  assign skid_load   = ~redirect & stall & resp_ok;
  assign skid_unload = ~redirect & ~stall & skid_full;

  always_comb begin
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    if (redirect) begin
      instr_d = INSTR_W'(NOP_INSTR);
      pc1_d   = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (skid_full) begin
        instr_d = skid_instr;
        pc1_d   = skid_pc1;
        valid_d = 1'b1;
      end else if (resp_ok) begin
        instr_d = imem.imem_rdata;
        pc1_d   = fetch_pc_q + 1'b1;
        valid_d = 1'b1;
      end else begin
        instr_d = INSTR_W'(NOP_INSTR);
        pc1_d   = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      instr_q    <= '0;
      pc1_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc1_q      <= pc1_d;
      valid_q    <= valid_d;
    end
  end

  fetch_skid_buf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clock    (clock),
    .rst_n    (rst_n),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (redirect),
    .instr_i  (imem.imem_rdata),
    .pc1_i    (fetch_pc_q + 1'b1),
    .full_o   (skid_full),
    .instr_o  (skid_instr),
    .pc1_o    (skid_pc1)
  );

  assign if_id_instr = instr_q;
  assign if_id_pc1   = pc1_q;
  assign if_id_valid = valid_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the 5-stage 16-bit pipeline. It sits directly upstream of the decode controller and drives the 16-bit instruction word whose bits [15:12] the controller decodes. It also consumes the controller's branch-taken and jump outputs to redirect the PC. It talks to instruction memory over a request/grant/response handshake with at most one outstanding fetch, and buffers one response under stall.

Parameters:
PC_W, 16, PC width; word-addressed, one instruction per word
INSTR_W, 16, instruction width
RESET_PC, 0, PC value loaded at reset

Ports:
clock  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  PC_W  fetch word address, equals pc_q
imem_gnt  in  1  memory accepts request this cycle (req&gnt = accept)
imem_rvalid  in  1  response data valid; arrives >=1 cycle after accept
imem_rdata  in  INSTR_W  fetched instruction
stall  in  1  hazard hold: IF/ID and PC must not advance
branch_en  in  1  taken branch from controller
jump  in  1  jump from controller
target  in  PC_W  redirect address, valid when branch_en|jump
if_id_instr  out  INSTR_W  instruction to controller (0x0000 = NOP)
if_id_pc1  out  PC_W  address of if_id_instr plus 1
if_id_valid  out  1  if_id_instr is a real fetched instruction

Behaviour:
- Reset (async, rst_n=0): pc_q=RESET_PC; state=IDLE; skid empty; if_id_instr=0; if_id_pc1=0; if_id_valid=0; imem_req=0. First request is issued in the first cycle after deassertion.
- States: IDLE (nothing outstanding), WAIT (one fetch outstanding), DROP (one fetch outstanding whose response must be discarded).
- imem_req = (state==IDLE) & !skid_valid & !redirect, where redirect = branch_en|jump. This is a combinational path from redirect to req by design. imem_addr = pc_q at all times.
- Accept (req&gnt): pc_q<=pc_q+1, wrapping modulo 2^PC_W; latch fetch_pc=pc_q; IDLE->WAIT. If req is high and gnt low, hold req and addr; no PC change.
- Response in WAIT: return to IDLE. The payload {imem_rdata, fetch_pc+1} goes:
  - to IF/ID with valid=1 if !stall;
  - to the skid buffer if stall.
- Response in DROP: discard the payload; DROP->IDLE.
- Redirect, which has priority over stall and over any response that cycle:
  - pc_q<=target.
  - IF/ID <= {0x0000, 0, valid=0}.
  - Skid cleared.
  - WAIT without rvalid -> DROP. WAIT with rvalid -> IDLE, data discarded. DROP stays DROP, or goes to IDLE if rvalid.
  - No accept can occur that cycle.
- Stall without redirect: IF/ID holds its value; pc_q changes only through an accept; requests continue until the skid is full.
- No stall, skid full: skid -> IF/ID with valid=1, skid empties. A simultaneous rvalid is impossible because no request is issued while the skid is full.
- No stall, skid empty, no usable response: IF/ID <= NOP bubble {0x0000, valid=0}. if_id_pc1 is don't-care but driven 0.
- Fetch-to-IF/ID latency: data is visible in IF/ID the cycle after imem_rvalid. With single-cycle memory (gnt=1, rvalid the cycle after accept), throughput is one instruction every 2 cycles.
- branch_en and jump both high: treated as a single redirect to target.
- Reset mid-fetch: the state clears; any late rvalid arriving in IDLE is ignored.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants OP_NOP=4'h0 ... OP_ADDI=4'hA, OP_LD=4'hB, OP_ST=4'hC, OP_BZ=4'hD, OP_JMP=4'hE;
  - NOP_INSTR=16'h0000;
  - fetch_state_t enum {IDLE, WAIT, DROP}.
- One sub-module: fetch_skid_buf, a 1-entry buffer with ports load, unload, clear, full, data {instr, pc1}. The PC, the FSM and the IF/ID register stay in fetch_stage.

Test Plan:
1. Reset release with gnt=1 and rvalid one cycle after accept, memory[0..2]=0x1123,0x2456,0xA701 -> imem_addr 0,1,2 in sequence; IF/ID shows 0x1123/pc1=1, then 0x2456/pc1=2, then 0xA701/pc1=3, valid=1 each time, with a bubble between them.
2. Hold gnt=0 for 3 cycles with req high -> imem_addr stays 0, pc_q unchanged, if_id_valid=0 throughout; the accept in cycle 4 proceeds normally.
3. Assert stall while the response 0x3111 arrives -> IF/ID keeps its old value, skid full, imem_req=0. Drop stall -> IF/ID=0x3111 valid=1 next cycle, then req resumes.
4. Assert jump with target=0x0040 in the cycle after an accept (rvalid late) -> state DROP, IF/ID=NOP valid=0; the late rvalid data is not seen in IF/ID; next imem_addr=0x0040.
5. branch_en=1 and rvalid in the same cycle while stall=1, target=0x0010 -> data discarded, skid empty, IF/ID=NOP valid=0, next request addr=0x0010.
6. pc_q=0xFFFF fetch accepted -> pc_q wraps to 0x0000; IF/ID pc1=0x0000. Pulse rst_n low mid-WAIT -> all outputs zero immediately, pc_q=RESET_PC.
